// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode pipeline stage.
// Decodes one instruction per cycle into datapath control fields held in an
// output register, with valid/ready handshakes on both sides, sticky HALT,
// branch flush, and optional load-use bubble insertion.
//
// Optional feature macro: DECODE_HAZARD_EN (load-use hazard detection and
// single-cycle bubble insertion). Undefined: no comparators, bubble = 0.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   inst, in_valid    incoming instruction word and its valid
//   in_ready          stage accepts inst this cycle (combinational)
//   flush             squash output register, clear halted
//   out_valid         output fields valid
//   out_ready         downstream consumes output this cycle
//   dr, sa, sb        register addresses
//   imm, off          immediate / branch offset
//   fs, bs            ALU function / branch select
//   mb, md, ld, mw, halt, illegal, bubble   control flags
module decode_stage #(
    parameter int unsigned REG_AW = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3*REG_AW+6:0]   inst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_AW-1:0]     dr,
    output logic [REG_AW-1:0]     sa,
    output logic [REG_AW-1:0]     sb,
    output logic [REG_AW+2:0]     imm,
    output logic [REG_AW+2:0]     off,
    output logic [2:0]            fs,
    output logic [2:0]            bs,
    output logic                  mb,
    output logic                  md,
    output logic                  ld,
    output logic                  mw,
    output logic                  halt,
    output logic                  illegal,
    output logic                  bubble
);

    localparam int unsigned IMM_W  = REG_AW + 3;
    localparam int unsigned INST_W = 3 * REG_AW + 7;

    typedef struct packed {
        logic [REG_AW-1:0] dr;
        logic [REG_AW-1:0] sa;
        logic [REG_AW-1:0] sb;
        logic [IMM_W-1:0]  imm;
        logic [IMM_W-1:0]  off;
        logic [2:0]        fs;
        logic [2:0]        bs;
        logic              mb;
        logic              md;
        logic              ld;
        logic              mw;
        logic              halt;
        logic              illegal;
    } dec_t;

    // Decoded NOP: everything zero except "no branch" select.
    function automatic dec_t nop_word();
        dec_t n;
        n    = '0;
        n.bs = 3'b100;
        return n;
    endfunction

    logic [3:0]        op;
    logic [2:0]        funct;
    logic [REG_AW-1:0] f_sa;
    logic [REG_AW-1:0] f_rsb;
    logic [REG_AW-1:0] f_rdr;
    logic [REG_AW-1:0] f_ireg;
    logic [IMM_W-1:0]  f_imm;

    dec_t dec;
    dec_t out_q;
    logic halted;
    logic hazard;
    logic accept;

    // Raw instruction field slices
    assign op     = inst[INST_W-1 -: 4];
    assign funct  = inst[2:0];
    assign f_sa   = inst[INST_W-5 -: REG_AW];
    assign f_rsb  = inst[INST_W-5-REG_AW -: REG_AW];
    assign f_rdr  = inst[INST_W-5-2*REG_AW -: REG_AW];
    assign f_ireg = inst[IMM_W+REG_AW-1 : IMM_W];
    assign f_imm  = inst[IMM_W-1:0];

    // Opcode decode into control fields
    always_comb begin
        dec = nop_word();
        unique case (op)
            4'b0000: dec.halt = (funct == 3'b001);
            4'b1111: begin
                dec.dr = f_rdr;
                dec.sa = f_sa;
                dec.sb = f_rsb;
                dec.fs = funct;
                dec.ld = 1'b1;
            end
            4'b1000, 4'b1001, 4'b1010, 4'b1011: begin
                dec.sa  = f_sa;
                dec.sb  = f_rsb;
                dec.off = f_imm;
                dec.bs  = {1'b0, op[1:0]};
            end
            4'b0010: begin
                dec.sa  = f_sa;
                dec.dr  = f_ireg;
                dec.imm = f_imm;
                dec.mb  = 1'b1;
                dec.md  = 1'b1;
                dec.ld  = 1'b1;
            end
            4'b0100: begin
                dec.sa  = f_sa;
                dec.sb  = f_ireg;
                dec.imm = f_imm;
                dec.mb  = 1'b1;
                dec.mw  = 1'b1;
            end
            4'b0101, 4'b0110, 4'b0111: begin
                dec.sa  = f_sa;
                dec.dr  = f_ireg;
                dec.imm = f_imm;
                dec.mb  = 1'b1;
                dec.ld  = 1'b1;
                dec.fs  = (op[1:0] == 2'b01) ? 3'b000 :
                          (op[1:0] == 2'b10) ? 3'b101 : 3'b110;
            end
            4'b0001, 4'b0011, 4'b1100, 4'b1101, 4'b1110: dec.illegal = 1'b1;
            default: ;
        endcase
        // Writes to r0 are discarded
        if (dec.dr == '0) begin
            dec.ld = 1'b0;
        end
    end

`ifdef DECODE_HAZARD_EN
    logic load_pending;
    logic bubble_q;

    // Decoded sa/sb are zero for forms that do not read them, so a nonzero
    // load destination can only match a register actually sourced.
    assign load_pending = out_valid & out_q.md & out_q.ld & (out_q.dr != '0);
    assign hazard       = load_pending & in_valid &
                          ((dec.sa == out_q.dr) | (dec.sb == out_q.dr));

    // Bubble flag tracks the output register contents
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_q <= 1'b0;
        end else if (flush || accept) begin
            bubble_q <= 1'b0;
        end else if (hazard && out_ready) begin
            bubble_q <= 1'b1;
        end
    end

    assign bubble = bubble_q;
`else
    assign hazard = 1'b0;
    assign bubble = 1'b0;
`endif

    assign in_ready = !halted && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Output pipeline register, valid and sticky halt
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q     <= nop_word();
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else if (flush) begin
            out_q     <= nop_word();
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else if (accept) begin
            out_q     <= dec;
            out_valid <= 1'b1;
            if (dec.halt) begin
                halted <= 1'b1;
            end
        end else if (hazard && out_ready) begin
            out_q     <= nop_word();
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign dr      = out_q.dr;
    assign sa      = out_q.sa;
    assign sb      = out_q.sb;
    assign imm     = out_q.imm;
    assign off     = out_q.off;
    assign fs      = out_q.fs;
    assign bs      = out_q.bs;
    assign mb      = out_q.mb;
    assign md      = out_q.md;
    assign ld      = out_q.ld;
    assign mw      = out_q.mw;
    assign halt    = out_q.halt;
    assign illegal = out_q.illegal;

endmodule
